ysyx_22040759_mem_arbiter: RTL and testbench
============================================

Name: ysyx_22040759_mem_arbiter

Overview:
Shares the single 64-bit RAMHelper-style memory port between the instruction-fetch requester (IF) and the load/store requester (D).
- Converts byte addresses to double-word indices.
- Sequences the one-cycle synchronous read latency.
- Selects the 32-bit instruction half for IF.
- Returns responses to each requester.
- Sits between the fetch/LSU stages and the memory model, replacing the per-stage private RAMHelper instances.

Parameters:
BASE_ADDR, 64'h0000_0000_8000_0000, physical base of memory; index = (addr - BASE_ADDR) >> 3
MAX_WAIT, 4, consecutive IF losses before IF is forced ahead of D (fixed-priority mode only)
NOP_INST, 32'h0000_0013, instruction returned for IF address 0 without touching RAM

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  64  fetch byte address, 4-byte aligned
if_ack  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch data valid, 1-cycle pulse
if_rdata  out  32  fetched instruction
d_req  in  1  data request, held until d_ack
d_we  in  1  1 = write, 0 = read
d_addr  in  64  data byte address, 8-byte aligned
d_wdata  in  64  write data
d_wmask  in  64  bit-granular write mask
d_ack  out  1  data request accepted this cycle
d_rvalid  out  1  data response valid (read data or write done), 1-cycle pulse
d_rdata  out  64  read data; 0 for writes
ram_en  out  1  RAM read enable
ram_ridx  out  64  RAM read index
ram_wen  out  1  RAM write enable
ram_widx  out  64  RAM write index
ram_wdata  out  64  RAM write data
ram_wmask  out  64  RAM write mask
ram_rdata  in  64  RAM read data, valid the cycle after ram_en

Behaviour:
- FSM states: IDLE, RESP_IF, RESP_D. All outputs are 0 on reset and state = IDLE. Reset is asynchronous, asserts any time, and takes effect immediately.
- Reset mid-transaction drops the in-flight response: no rvalid follows.

IDLE:
- Arbitrate among pending requests; at most one ack per cycle.
- The ack is combinational in the issue cycle.
- RAM signals are driven combinationally for the granted request only; all RAM outputs are 0 otherwise.
- IF grant:
  - Drive ram_en=1 and ram_ridx=(if_addr-BASE_ADDR)>>3.
  - Latch if_addr[2]; go to RESP_IF.
  - If if_addr==0: ram_en stays 0 and NOP_INST is latched instead.
- D read grant: drive ram_en=1 and ram_ridx=(d_addr-BASE_ADDR)>>3; go to RESP_D.
- D write grant: drive ram_wen=1, ram_widx, ram_wdata and ram_wmask; ram_en=0; go to RESP_D.

RESP_IF:
- if_rvalid=1.
- if_rdata = ram_rdata[31:0] if latched addr[2]==0, else ram_rdata[63:32], or NOP_INST if the zero-address case applies.
- No ack is issued in this state. Return to IDLE.

RESP_D:
- d_rvalid=1; d_rdata=ram_rdata for reads, 0 for writes.
- Return to IDLE.

General rules:
- Throughput is one transaction per 2 cycles. The response arrives exactly 1 cycle after the ack.
- Responses have no backpressure: the requester must sample them on rvalid.
- Fixed priority: D wins over IF, except when starve_cnt==MAX_WAIT.
  - starve_cnt increments when IF is pending and D is granted.
  - It clears on IF grant or when if_req=0, and saturates at MAX_WAIT.
- Index arithmetic is 64-bit wrap-around subtraction; addresses below BASE_ADDR are not range-checked.
- A request deasserted before ack is dropped silently. Requests arriving in RESP_* wait until IDLE.

Optional Feature:
Macro: YSYX_22040759_ARB_RR_EN.
- Defined: strict round-robin arbitration.
  - A 1-bit last-grant register (reset = IF, so D wins the first tie).
  - When both request, the one not granted last wins.
  - starve_cnt and MAX_WAIT are unused.
- Undefined: fixed D-priority with the MAX_WAIT anti-starvation override described above.

Test Plan:
- Reset with if_req=1, if_addr=64'h8000_0004; RAM word 0 = 64'hAAAA_BBBB_CCCC_DDDD -> cycle 0: if_ack=1, ram_ridx=0; cycle 1: if_rvalid=1, if_rdata=32'hAAAA_BBBB.
- if_addr=64'h0 -> if_ack=1 and ram_en=0; next cycle if_rdata=32'h0000_0013.
- D write d_addr=64'h8000_0010, wdata=64'h1122_3344_5566_7788, wmask all-ones -> ram_wen=1, ram_widx=2; next cycle d_rvalid=1, d_rdata=0. Then a read of the same address returns 64'h1122_3344_5566_7788.
- if_req and d_req held continuously (fixed priority, MAX_WAIT=4) -> grant order D,D,D,D,IF,D,D,D,D,IF; no ack appears in response cycles.
- With YSYX_22040759_ARB_RR_EN, both held -> grants alternate D,IF,D,IF.
- Assert rst_n=0 in RESP_D -> d_rvalid stays 0, all outputs 0, FSM in IDLE; after release a fresh request completes normally.

Source files
------------

// File: rtl/ysyx_22040759_mem_arbiter_if.sv
// rtl/ysyx_22040759_mem_arbiter_if.sv - fetch, load/store and RAM port bundle of the memory arbiter
interface ysyx_22040759_mem_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ack;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_wmask;
  logic        d_ack;
  logic        d_rvalid;
  logic [63:0] d_rdata;

  logic        ram_en;
  logic [63:0] ram_ridx;
  logic        ram_wen;
  logic [63:0] ram_widx;
  logic [63:0] ram_wdata;
  logic [63:0] ram_wmask;
  logic [63:0] ram_rdata;

  // arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, ram_rdata,
    output if_ack, if_rvalid, if_rdata, d_ack, d_rvalid, d_rdata,
    output ram_en, ram_ridx, ram_wen, ram_widx, ram_wdata, ram_wmask
  );

  // requester and memory-model side
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, ram_rdata,
    input  if_ack, if_rvalid, if_rdata, d_ack, d_rvalid, d_rdata,
    input  ram_en, ram_ridx, ram_wen, ram_widx, ram_wdata, ram_wmask
  );
endinterface

// File: rtl/ysyx_22040759_mem_arbiter.sv
// rtl/ysyx_22040759_mem_arbiter.sv - shares one 64-bit RAMHelper port between instruction fetch and load/store
// Define YSYX_22040759_ARB_RR_EN for round-robin arbitration; default is D-priority with IF anti-starvation.
module ysyx_22040759_mem_arbiter #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int          MAX_WAIT  = 4,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ysyx_22040759_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D} state_t;

  state_t      state, state_next;
  logic        grant_if, grant_d;
  logic        if_zero;
  logic [63:0] if_idx, d_idx;
  logic        lat_hi, lat_nop, lat_we;

  assign if_zero = (bus.if_addr == 64'd0);
  assign if_idx  = (bus.if_addr - BASE_ADDR) >> 3;
  assign d_idx   = (bus.d_addr - BASE_ADDR) >> 3;

`ifdef YSYX_22040759_ARB_RR_EN
  logic last_grant_d;

  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (rst_n && state == IDLE) begin
      if (bus.if_req && bus.d_req) begin
        grant_if = last_grant_d;
        grant_d  = !last_grant_d;
      end else begin
        grant_if = bus.if_req;
        grant_d  = bus.d_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_d <= 1'b0;
    end else if (grant_if || grant_d) begin
      last_grant_d <= grant_d;
    end
  end
`else
  localparam int SW = $clog2(MAX_WAIT + 1);
  logic [SW-1:0] starve_cnt;

  // IF is forced ahead once it has lost MAX_WAIT grants in a row
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (rst_n && state == IDLE) begin
      if (bus.d_req && !(bus.if_req && starve_cnt == SW'(MAX_WAIT))) begin
        grant_d = 1'b1;
      end else begin
        grant_if = bus.if_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!bus.if_req || grant_if) begin
      starve_cnt <= '0;
    end else if (grant_d && starve_cnt != SW'(MAX_WAIT)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end
`endif

  always_comb begin
    state_next    = state;
    bus.if_ack    = grant_if;
    bus.d_ack     = grant_d;
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = 32'd0;
    bus.d_rvalid  = 1'b0;
    bus.d_rdata   = 64'd0;
    bus.ram_en    = 1'b0;
    bus.ram_ridx  = 64'd0;
    bus.ram_wen   = 1'b0;
    bus.ram_widx  = 64'd0;
    bus.ram_wdata = 64'd0;
    bus.ram_wmask = 64'd0;
    case (state)
      IDLE: begin
        if (grant_if) begin
          state_next = RESP_IF;
          if (!if_zero) begin
            bus.ram_en   = 1'b1;
            bus.ram_ridx = if_idx;
          end
        end else if (grant_d) begin
          state_next = RESP_D;
          if (bus.d_we) begin
            bus.ram_wen   = 1'b1;
            bus.ram_widx  = d_idx;
            bus.ram_wdata = bus.d_wdata;
            bus.ram_wmask = bus.d_wmask;
          end else begin
            bus.ram_en   = 1'b1;
            bus.ram_ridx = d_idx;
          end
        end
      end
      RESP_IF: begin
        state_next    = IDLE;
        bus.if_rvalid = 1'b1;
        if (lat_nop) begin
          bus.if_rdata = NOP_INST;
        end else begin
          bus.if_rdata = lat_hi ? bus.ram_rdata[63:32] : bus.ram_rdata[31:0];
        end
      end
      RESP_D: begin
        state_next   = IDLE;
        bus.d_rvalid = 1'b1;
        bus.d_rdata  = lat_we ? 64'd0 : bus.ram_rdata;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lat_hi  <= 1'b0;
      lat_nop <= 1'b0;
      lat_we  <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_if) begin
        lat_hi  <= bus.if_addr[2];
        lat_nop <= if_zero;
      end
      if (grant_d) begin
        lat_we <= bus.d_we;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
// tb/tb_ysyx_22040759_mem_arbiter.sv - directed and randomized checks of the fetch/load-store memory arbiter
module tb_ysyx_22040759_mem_arbiter;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam int          MAXW = 4;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_22040759_mem_arbiter_if bus ();

  ysyx_22040759_mem_arbiter #(
    .BASE_ADDR(BASE),
    .MAX_WAIT (MAXW),
    .NOP_INST (NOP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [63:0] init_word(int i);
    if (i == 0) return 64'hAAAA_BBBB_CCCC_DDDD;
    return {8'(i), 24'h5A5A5A, 8'(i), 24'hA5A5A5};
  endfunction

  function automatic logic [63:0] idx(logic [63:0] a);
    return (a - BASE) >> 3;
  endfunction

  // memory model with one-cycle synchronous read
  logic [63:0] mem [0:255];
  bit ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else begin
      if (bus.ram_en) bus.ram_rdata <= mem[bus.ram_ridx[7:0]];
      if (bus.ram_wen)
        mem[bus.ram_widx[7:0]] <= (mem[bus.ram_widx[7:0]] & ~bus.ram_wmask) |
                                  (bus.ram_wdata & bus.ram_wmask);
    end
  end

  // reference model state
  logic [63:0] ref_mem [0:255];
  bit          m_busy, m_kind_if, m_g_if, m_g_d, m_last_d;
  int          m_starve;
  logic [63:0] m_pend;

  int errors = 0;
  int checks = 0;

  logic        obs_if_ack, obs_d_ack, obs_ram_en, obs_ram_wen, obs_d_rvalid;
  logic [63:0] obs_ridx, obs_widx, obs_d_rdata;
  logic [31:0] obs_if_rdata;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_starve = 0;
    m_last_d = 1'b0;
    m_g_if   = 1'b0;
    m_g_d    = 1'b0;
  endtask

  // one clock: check outputs at the falling edge, advance model, return 1 after the next rising edge
  task automatic cycle();
    bit          g_if, g_d, e_en, e_wen;
    logic [63:0] e_ridx, e_widx, e_wdata, e_wmask, k;
    @(negedge clk);
    g_if = 1'b0;
    g_d  = 1'b0;
    if (!m_busy) begin
      if (bus.if_req && bus.d_req) begin
`ifdef YSYX_22040759_ARB_RR_EN
        if (m_last_d) g_if = 1'b1; else g_d = 1'b1;
`else
        if (m_starve >= MAXW) g_if = 1'b1; else g_d = 1'b1;
`endif
      end else begin
        g_if = bus.if_req;
        g_d  = bus.d_req;
      end
    end
    e_en    = (g_if && bus.if_addr != 64'd0) || (g_d && !bus.d_we);
    e_ridx  = (g_if && bus.if_addr != 64'd0) ? idx(bus.if_addr) :
              (g_d && !bus.d_we) ? idx(bus.d_addr) : 64'd0;
    e_wen   = g_d && bus.d_we;
    e_widx  = e_wen ? idx(bus.d_addr) : 64'd0;
    e_wdata = e_wen ? bus.d_wdata : 64'd0;
    e_wmask = e_wen ? bus.d_wmask : 64'd0;

    chk("if_ack",    64'(bus.if_ack),    64'(g_if));
    chk("d_ack",     64'(bus.d_ack),     64'(g_d));
    chk("ram_en",    64'(bus.ram_en),    64'(e_en));
    chk("ram_ridx",  bus.ram_ridx,       e_ridx);
    chk("ram_wen",   64'(bus.ram_wen),   64'(e_wen));
    chk("ram_widx",  bus.ram_widx,       e_widx);
    chk("ram_wdata", bus.ram_wdata,      e_wdata);
    chk("ram_wmask", bus.ram_wmask,      e_wmask);
    chk("if_rvalid", 64'(bus.if_rvalid), 64'(m_busy && m_kind_if));
    chk("d_rvalid",  64'(bus.d_rvalid),  64'(m_busy && !m_kind_if));
    if (m_busy && m_kind_if)  chk("if_rdata", 64'(bus.if_rdata), m_pend);
    if (m_busy && !m_kind_if) chk("d_rdata",  bus.d_rdata,       m_pend);

    obs_if_ack   = bus.if_ack;
    obs_d_ack    = bus.d_ack;
    obs_ram_en   = bus.ram_en;
    obs_ram_wen  = bus.ram_wen;
    obs_ridx     = bus.ram_ridx;
    obs_widx     = bus.ram_widx;
    obs_d_rvalid = bus.d_rvalid;
    obs_d_rdata  = bus.d_rdata;
    obs_if_rdata = bus.if_rdata;

    m_busy = g_if || g_d;
    m_g_if = g_if;
    m_g_d  = g_d;
    if (g_if) begin
      m_kind_if = 1'b1;
      k = idx(bus.if_addr);
      if (bus.if_addr == 64'd0)  m_pend = {32'd0, NOP};
      else if (bus.if_addr[2])   m_pend = {32'd0, ref_mem[k[7:0]][63:32]};
      else                       m_pend = {32'd0, ref_mem[k[7:0]][31:0]};
      m_last_d = 1'b0;
      m_starve = 0;
    end
    if (g_d) begin
      m_kind_if = 1'b0;
      k = idx(bus.d_addr);
      if (bus.d_we) begin
        ref_mem[k[7:0]] = (ref_mem[k[7:0]] & ~bus.d_wmask) | (bus.d_wdata & bus.d_wmask);
        m_pend = 64'd0;
      end else begin
        m_pend = ref_mem[k[7:0]];
      end
      m_last_d = 1'b1;
      if (bus.if_req && m_starve < MAXW) m_starve++;
    end
    if (!bus.if_req) m_starve = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    string exp_seq;
    int    gi;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    model_reset();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h8000_0004;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 64'd0;
    bus.d_wdata = 64'd0;
    bus.d_wmask = 64'd0;

    // outputs quiet while reset is held, even with a request pending
    @(negedge clk);
    chk("rst_if_ack",    64'(bus.if_ack),    64'd0);
    chk("rst_d_ack",     64'(bus.d_ack),     64'd0);
    chk("rst_ram_en",    64'(bus.ram_en),    64'd0);
    chk("rst_ram_ridx",  bus.ram_ridx,       64'd0);
    chk("rst_ram_wen",   64'(bus.ram_wen),   64'd0);
    chk("rst_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    chk("rst_d_rvalid",  64'(bus.d_rvalid),  64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    cycle();
    chk("tp1_if_ack", 64'(obs_if_ack), 64'd1);
    chk("tp1_ridx",   obs_ridx,        64'd0);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = BASE + 64'd8;
    cycle();
    chk("tp1_if_rdata", 64'(obs_if_rdata), 64'hAAAA_BBBB);

    // both requesters held: record grant order
`ifdef YSYX_22040759_ARB_RR_EN
    exp_seq = "DIDIDIDIDI";
`else
    exp_seq = "DDDDIDDDDI";
`endif
    gi = 0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (obs_d_ack || obs_if_ack) begin
        if (gi < 10) chk("grant_order", obs_d_ack ? 64'd68 : 64'd73, 64'(exp_seq[gi]));
        gi++;
      end
    end
    chk("grant_count", 64'(gi), 64'd10);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    cycle();

    // fetch from address 0 returns NOP without RAM access
    bus.if_req  = 1'b1;
    bus.if_addr = 64'd0;
    cycle();
    chk("nop_ack",    64'(obs_if_ack), 64'd1);
    chk("nop_ram_en", 64'(obs_ram_en), 64'd0);
    bus.if_req = 1'b0;
    cycle();
    chk("nop_rdata", 64'(obs_if_rdata), 64'h13);

    // write then read back
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 64'h8000_0010;
    bus.d_wdata = 64'h1122_3344_5566_7788;
    bus.d_wmask = '1;
    cycle();
    chk("wr_wen",  64'(obs_ram_wen), 64'd1);
    chk("wr_widx", obs_widx,         64'd2);
    bus.d_req = 1'b0;
    cycle();
    chk("wr_rvalid", 64'(obs_d_rvalid), 64'd1);
    chk("wr_rdata",  obs_d_rdata,       64'd0);
    bus.d_req = 1'b1;
    bus.d_we  = 1'b0;
    cycle();
    bus.d_req = 1'b0;
    cycle();
    chk("rd_rdata", obs_d_rdata, 64'h1122_3344_5566_7788);

    // address below the base wraps in 64 bits
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h8;
    cycle();
    chk("wrap_ridx", obs_ridx, 64'h1FFF_FFFF_F000_0001);
    bus.if_req = 1'b0;
    cycle();

    // reset during a data response drops it
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 64'h8000_0010;
    cycle();
    bus.d_req   = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = BASE;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_d_rvalid",  64'(bus.d_rvalid),  64'd0);
    chk("rst_mid_d_rdata",   bus.d_rdata,        64'd0);
    chk("rst_mid_if_ack",    64'(bus.if_ack),    64'd0);
    chk("rst_mid_ram_en",    64'(bus.ram_en),    64'd0);
    chk("rst_mid_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    chk("post_rst_ack", 64'(obs_if_ack), 64'd1);
    bus.if_req = 1'b0;
    cycle();
    chk("post_rst_rdata", 64'(obs_if_rdata), 64'hCCCC_DDDD);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      if (m_g_if) bus.if_req = 1'b0;
      if (m_g_d)  bus.d_req  = 1'b0;
      if (!bus.if_req) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.if_req  = 1'b1;
          bus.if_addr = ($urandom_range(0, 7) == 0) ? 64'd0 : BASE + 64'(4 * $urandom_range(0, 511));
        end
      end else if ($urandom_range(0, 15) == 0) begin
        bus.if_req = 1'b0;
      end
      if (!bus.d_req) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.d_req   = 1'b1;
          bus.d_we    = $urandom_range(0, 1) == 1;
          bus.d_addr  = BASE + 64'(8 * $urandom_range(0, 255));
          bus.d_wdata = {$urandom, $urandom};
          bus.d_wmask = ($urandom_range(0, 1) == 1) ? '1 : {$urandom, $urandom};
        end
      end else if ($urandom_range(0, 15) == 0) begin
        bus.d_req = 1'b0;
      end
      cycle();
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
